// File: rtl/dbus_sram_responder.sv
// ============================================================================
// dbus_sram_responder : word-organised SRAM servicing dbus requests with a
//                       fixed latency, byte-strobe writes and error flagging
// Revision            : 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err,
    output logic       viol,
    output logic       busy
);
    localparam int unsigned c_AW    = $clog2(DEPTH);
    localparam logic [63:0] c_LIMIT = BASE_ADDR + 64'(DEPTH) * 64'd8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [3:0]      r_cnt;
    logic [63:0]     r_addr;
    logic [7:0]      r_strobe;
    logic [63:0]     r_data;
    logic            r_viol;
    logic            r_ok;
    logic            r_err;
    logic [63:0]     r_rdata;
    logic [63:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_access;
    logic            w_we;
    logic            w_chk;
    logic [63:0]     w_addr;
    logic [7:0]      w_strobe;
    logic [63:0]     w_wdata;
    logic [63:0]     w_off;
    logic [c_AW-1:0] w_idx;
    logic            w_in_range;
    logic            w_unused;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (dreq.valid) w_next = (LATENCY == 1) ? c_RESP : c_WAIT;
            c_WAIT:  if (r_cnt == 4'd1) w_next = c_RESP;
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept = (r_state == c_IDLE) && dreq.valid;
        w_access = (w_accept && (LATENCY == 1)) || ((r_state == c_WAIT) && (r_cnt == 4'd1));
        w_chk    = (r_state == c_WAIT) &&
                   (!dreq.valid || (dreq.addr != r_addr) ||
                    (dreq.strobe != r_strobe) || (dreq.data != r_data));
        busy     = (r_state != c_IDLE);
    end

    // With LATENCY==1 the access happens on the accepting edge, before latching
    always_comb begin
        w_addr   = r_addr;
        w_strobe = r_strobe;
        w_wdata  = r_data;
        if (r_state == c_IDLE) begin
            w_addr   = dreq.addr;
            w_strobe = dreq.strobe;
            w_wdata  = dreq.data;
        end
    end

    assign w_off      = w_addr - BASE_ADDR;
    assign w_idx      = w_off[c_AW+2:3];
    assign w_in_range = (w_addr >= BASE_ADDR) && (w_addr < c_LIMIT);
    // Reset gates the write so an abandoned transaction never commits
    assign w_we       = w_access && w_in_range && (w_strobe != 8'd0) && reset;
    assign w_unused   = ^{dreq.size, w_off[63:c_AW+3], w_off[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 4'd0;
            r_addr   <= 64'd0;
            r_strobe <= 8'd0;
            r_data   <= 64'd0;
            r_viol   <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 64'd0;
        end else begin
            if (w_accept) begin
                r_addr   <= dreq.addr;
                r_strobe <= dreq.strobe;
                r_data   <= dreq.data;
                r_cnt    <= 4'(LATENCY - 1);
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_chk) begin
                r_viol <= 1'b1;
            end
            r_ok  <= w_access;
            r_err <= w_access && !w_in_range;
            if (w_access) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : 64'd0;
            end
        end
    end

    // Array has no reset; read above sees the pre-write word on the same edge
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = r_ok;
    assign dresp.data_ok = r_ok;
    assign dresp.data    = r_rdata;
    assign err           = r_err;
    assign viol          = r_viol;

endmodule

`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
// ============================================================================
// tb_dbus_sram_responder : scoreboard bench for three responders with
//                          LATENCY 1, 2 and 3 sharing one clock
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    typedef struct {
        logic [63:0] data;
        logic        err;
        bit          chk;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq_s  [3];
    dbus_resp_t dresp_s [3];
    logic       err_s   [3];
    logic       viol_s  [3];
    logic       busy_s  [3];

    exp_t        exp_q [3][$];
    exp_t        m_e;
    logic [63:0] mem_m [3][DEPTH];
    bit          known [3][DEPTH];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_sram_responder #(
            .DEPTH     (DEPTH),
            .LATENCY   (g + 1),
            .BASE_ADDR (BASE)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .dreq  (dreq_s[g]),
            .dresp (dresp_s[g]),
            .err   (err_s[g]),
            .viol  (viol_s[g]),
            .busy  (busy_s[g])
        );
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: the memory as an array of words with byte merges
    function automatic exp_t model(input int k, input logic [63:0] a, input logic [7:0] s,
                                   input logic [63:0] d);
        exp_t e;
        int   idx;
        e.cyc = 0;
        if (a < BASE || a >= LIMIT) begin
            e.err  = 1'b1;
            e.data = 64'd0;
            e.chk  = 1'b1;
        end else begin
            idx    = int'((a - BASE) / 64'd8);
            e.err  = 1'b0;
            e.data = mem_m[k][idx];
            e.chk  = known[k][idx];
            for (int i = 0; i < 8; i++)
                if (s[i]) mem_m[k][idx][8*i +: 8] = d[8*i +: 8];
            if (s == 8'hFF) known[k][idx] = 1'b1;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per data_ok
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("addr_ok_eq_data_ok[%0d]", k), dresp_s[k].addr_ok, dresp_s[k].data_ok);
            if (dresp_s[k].data_ok) begin
                if (exp_q[k].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp[%0d]: data_ok with empty scoreboard (cycle %0d)", k, cyc);
                end else begin
                    m_e = exp_q[k].pop_front();
                    chk($sformatf("resp_cycle[%0d]", k), 64'(cyc), 64'(m_e.cyc));
                    chk($sformatf("err[%0d]", k), err_s[k], m_e.err);
                    if (m_e.chk) chk($sformatf("rdata[%0d]", k), dresp_s[k].data, m_e.data);
                end
            end else begin
                chk($sformatf("err_idle[%0d]", k), err_s[k], 1'b0);
            end
        end
    end

    // Entered and left at #1 after a rising edge; valid appears in the current cycle
    task automatic txn(input int k, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input bit mutate, output logic [63:0] rd);
        exp_t e;
        bit   got;
        int   lat;
        lat   = k + 1;
        e     = model(k, a, s, d);
        e.cyc = cyc + lat;
        exp_q[k].push_back(e);
        dreq_s[k].valid  = 1'b1;
        dreq_s[k].addr   = a;
        dreq_s[k].size   = 3'd3;
        dreq_s[k].strobe = s;
        dreq_s[k].data   = d;
        got = 1'b0;
        rd  = 64'd0;
        @(negedge clk);
        chk($sformatf("busy_pre[%0d]", k), busy_s[k], 1'b0);
        for (int c = 1; c <= lat + 4; c++) begin
            @(posedge clk);
            #1;
            if (mutate && c == 1) dreq_s[k].addr = a ^ 64'h40;
            @(negedge clk);
            if (mutate && c <= 2) chk($sformatf("viol_rise[%0d]", k), viol_s[k], (c == 2));
            chk($sformatf("busy[%0d]", k), busy_s[k], 1'b1);
            if (dresp_s[k].data_ok) begin
                got = 1'b1;
                rd  = dresp_s[k].data;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout[%0d]: no data_ok within %0d cycles of addr %h", k, lat + 4, a);
        end
        @(posedge clk);
        #1;
        dreq_s[k] = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] a;
        logic [7:0]  s;
        int          k;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) dreq_s[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_data_ok[%0d]", i), dresp_s[i].data_ok, 1'b0);
            chk($sformatf("rst_data[%0d]", i), dresp_s[i].data, 64'd0);
            chk($sformatf("rst_viol[%0d]", i), viol_s[i], 1'b0);
            chk($sformatf("rst_busy[%0d]", i), busy_s[i], 1'b0);
        end
        reset = 1'b1;

        // Fill every word of every instance
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < DEPTH; w++)
                txn(i, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom}, 1'b0, rd);

        // Contents survive reset; LATENCY=2 read of word 0
        pulse_reset();
        @(posedge clk);
        #1;
        txn(1, BASE, 8'h00, 64'd0, 1'b0, rd);
        chk("t1_data", rd, mem_m[1][0]);

        // Full write, partial write, read back
        txn(1, BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, rd);
        txn(1, BASE + 64'h10, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, rd);
        chk("t2_prewrite", rd, 64'h1122_3344_5566_7788);
        txn(1, BASE + 64'h10, 8'h00, 64'd0, 1'b0, rd);
        chk("t2_merged", rd, 64'h1122_3344_AAAA_AAAA);

        // LATENCY=1 back-to-back reads
        for (int i = 3; i < 6; i++) txn(0, BASE + 64'(i) * 8, 8'h00, 64'd0, 1'b0, rd);

        // Out-of-range on both sides, then a write that must not land
        txn(1, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, rd);
        chk("t4_low_data", rd, 64'd0);
        txn(1, LIMIT, 8'h00, 64'd0, 1'b0, rd);
        chk("t4_high_data", rd, 64'd0);
        txn(1, LIMIT, 8'hFF, 64'hFF, 1'b0, rd);
        txn(1, LIMIT - 8, 8'h00, 64'd0, 1'b0, rd);
        chk("t4_last_word", rd, mem_m[1][DEPTH-1]);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 1) ? BASE - 64'(8 * (1 + $urandom_range(0, 3)))
                                                : LIMIT + 64'(8 * $urandom_range(0, 3));
            else
                a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 1) ? 8'(($urandom)) : 8'h00;
            txn(k, a, s, {$urandom, $urandom}, 1'b0, rd);
        end

        // Address changes while in flight (LATENCY=3)
        txn(2, BASE + 64'h18, 8'h00, 64'd0, 1'b1, rd);
        chk("t5_orig_addr", rd, mem_m[2][3]);
        @(negedge clk);
        chk("t5_sticky", viol_s[2], 1'b1);
        chk("t5_others0", viol_s[0], 1'b0);
        chk("t5_others1", viol_s[1], 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in WAIT of a write
        dreq_s[2].valid  = 1'b1;
        dreq_s[2].addr   = BASE + 64'h20;
        dreq_s[2].size   = 3'd3;
        dreq_s[2].strobe = 8'hFF;
        dreq_s[2].data   = ~mem_m[2][4];
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_busy_before", busy_s[2], 1'b1);
        reset = 1'b0;
        dreq_s[2] = '0;
        #1;
        chk("t6_busy", busy_s[2], 1'b0);
        chk("t6_viol", viol_s[2], 1'b0);
        chk("t6_data", dresp_s[2].data, 64'd0);
        chk("t6_data_ok", dresp_s[2].data_ok, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        txn(2, BASE + 64'h20, 8'h00, 64'd0, 1'b0, rd);
        chk("t6_old_data", rd, mem_m[2][4]);
        txn(0, BASE + 64'h20, 8'h00, 64'd0, 1'b0, rd);

        repeat (4) @(posedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("drain[%0d]", i), 64'(exp_q[i].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
